// File: rtl/node_tokenizer.sv
// Tokenizer for a graph listing of the form "abc: def ghi\n": emits each
// three-letter node name with head/end-of-line flags through a one-stage output register.
module node_tokenizer #(
  parameter int LINE_CNT_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_vld,
  input  logic [7:0]            i_char,
  output logic                  o_stall,
  output logic                  o_node_vld,
  output logic [14:0]           o_node_str,
  output logic                  o_head,
  output logic                  o_eol,
  input  logic                  i_stall,
  output logic                  o_done,
  output logic                  o_error,
  output logic [LINE_CNT_W-1:0] o_line_cnt
);

  typedef enum logic [2:0] {
    LINE_START,
    HEAD,
    DEST_GAP,
    DEST,
    DONE,
    ERR
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [14:0] sr_reg, sr_next;
  logic        emit, emit_head, emit_eol, line_inc;
  logic        accept, is_letter;
  logic [4:0]  letter;

  assign o_stall   = o_node_vld & i_stall;
  assign accept    = i_vld & ~o_stall;
  assign is_letter = (i_char >= 8'h61) && (i_char <= 8'h7A);
  // 'a'..'z' have low five bits 1..26, so subtracting one yields the letter index
  assign letter    = i_char[4:0] - 5'd1;

  assign o_done  = (state_reg == DONE);
  assign o_error = (state_reg == ERR);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sr_next    = sr_reg;
    emit       = 1'b0;
    emit_head  = 1'b0;
    emit_eol   = 1'b0;
    line_inc   = 1'b0;
    if (accept && state_reg != DONE && state_reg != ERR && i_char != 8'h0D) begin
      if (is_letter) begin
        if (cnt_reg == 2'd3) begin
          state_next = ERR;
        end else begin
          sr_next  = {sr_reg[9:0], letter};
          cnt_next = cnt_reg + 2'd1;
          if (state_reg == LINE_START) state_next = HEAD;
          else if (state_reg == DEST_GAP) state_next = DEST;
        end
      end else begin
        // every non-letter falls into ERR unless a case below recognises it
        state_next = ERR;
        case (state_reg)
          LINE_START: begin
            if (i_char == 8'h0A || i_char == 8'h00) state_next = DONE;
          end
          HEAD: begin
            if (i_char == 8'h3A && cnt_reg == 2'd3) begin
              emit       = 1'b1;
              emit_head  = 1'b1;
              cnt_next   = 2'd0;
              state_next = DEST_GAP;
            end
          end
          DEST_GAP: begin
            if (i_char == 8'h20) state_next = DEST_GAP;
          end
          DEST: begin
            if (cnt_reg == 2'd3 && i_char == 8'h20) begin
              emit       = 1'b1;
              cnt_next   = 2'd0;
              state_next = DEST_GAP;
            end else if (cnt_reg == 2'd3 && i_char == 8'h0A) begin
              emit       = 1'b1;
              emit_eol   = 1'b1;
              line_inc   = 1'b1;
              cnt_next   = 2'd0;
              state_next = LINE_START;
            end
          end
          default: state_next = state_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= LINE_START;
      cnt_reg   <= 2'd0;
      sr_reg    <= 15'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sr_reg    <= sr_next;
    end
  end

  // A byte is only accepted when the register is empty or being taken, so emit may overwrite.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_node_vld <= 1'b0;
      o_node_str <= 15'd0;
      o_head     <= 1'b0;
      o_eol      <= 1'b0;
    end else if (emit) begin
      o_node_vld <= 1'b1;
      o_node_str <= sr_reg;
      o_head     <= emit_head;
      o_eol      <= emit_eol;
    end else if (o_node_vld && !i_stall) begin
      o_node_vld <= 1'b0;
      o_node_str <= 15'd0;
      o_head     <= 1'b0;
      o_eol      <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_line_cnt <= '0;
    end else if (line_inc && o_line_cnt != {LINE_CNT_W{1'b1}}) begin
      o_line_cnt <= o_line_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_node_tokenizer.sv
// Scoreboard bench for node_tokenizer: expected tokens are queued by the stimulus
// and popped by a monitor whenever the DUT hands over a token.
module tb_node_tokenizer;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_vld = 1'b0;
  logic [7:0]   i_char = 8'h00;
  logic         i_stall = 1'b0;
  logic         o_stall, o_node_vld, o_head, o_eol, o_done, o_error;
  logic [14:0]  o_node_str;
  logic [W-1:0] o_line_cnt;

  logic [16:0]  exp_q[$];
  logic [16:0]  mon_e;
  int           total = 0;
  int           bad = 0;
  logic         stall_arm = 1'b0;
  logic         stall_seen = 1'b0;

  node_tokenizer #(.LINE_CNT_W(W)) dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_char(i_char), .o_stall(o_stall),
    .o_node_vld(o_node_vld), .o_node_str(o_node_str), .o_head(o_head), .o_eol(o_eol),
    .i_stall(i_stall), .o_done(o_done), .o_error(o_error), .o_line_cnt(o_line_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [14:0] s, input logic h, input logic e);
    exp_q.push_back({s, h, e});
  endtask

  task automatic send(input logic [7:0] c);
    int g;
    @(negedge clk);
    i_vld = 1'b1;
    i_char = c;
    #1;
    g = 0;
    while (o_stall && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 50) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=stalled required=accepted char=%h", c);
    end
    @(posedge clk);
    #1;
    i_vld = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_vld", o_node_vld, 0);
    chk("rst_str", o_node_str, 0);
    chk("rst_flags", {o_head, o_eol, o_stall}, 0);
    chk("rst_done_err", {o_done, o_error}, 0);
    chk("rst_line_cnt", o_line_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic settle_check(input string name, input logic done, input logic err,
                              input logic [W-1:0] lines);
    repeat (4) @(negedge clk);
    #3;
    chk({name, "_queue_left"}, exp_q.size(), 0);
    chk({name, "_done"}, o_done, done);
    chk({name, "_error"}, o_error, err);
    chk({name, "_line_cnt"}, o_line_cnt, lines);
    $display("scenario %s done=%0b error=%0b lines=%0d", name, o_done, o_error, o_line_cnt);
  endtask

  // Monitor: a token is handed over at the next rising edge when valid and not stalled.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst && o_node_vld && !i_stall) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_token actual=%h head=%0b eol=%0b required=none",
                 o_node_str, o_head, o_eol);
      end else begin
        mon_e = exp_q.pop_front();
        chk("token", {15'd0, o_node_str, o_head, o_eol}, {15'd0, mon_e});
        $display("token str=%h head=%0b eol=%0b", o_node_str, o_head, o_eol);
      end
    end
  end

  // Downstream back-pressure: hold the 0x0C02 token for five cycles once armed.
  initial forever begin
    @(negedge clk);
    if (stall_arm && o_node_vld && o_node_str == 15'h0C02) begin
      stall_arm = 1'b0;
      i_stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
        #1;
        chk("stall_held_str", o_node_str, 15'h0C02);
        chk("stall_o_stall", {o_stall, i_vld}, 2'b11);
        @(negedge clk);
      end
      i_stall = 1'b0;
      stall_seen = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    push(15'h4AB1, 1, 0); push(15'h14B3, 0, 0); push(15'h3A93, 0, 1);
    send_str("svr: fft out\n\n");
    settle_check("basic", 1, 0, 1);
    send_str("abc");
    settle_check("done_absorb", 1, 0, 1);

    do_reset();
    stall_arm = 1'b1;
    push(15'h0C02, 1, 0); push(15'h3A93, 0, 1);
    send_str("dac: out\n");
    settle_check("stall", 0, 0, 1);
    chk("stall_seen", stall_seen, 1);

    do_reset();
    send_str("abcd");
    chk("four_letter_err", o_error, 1);
    send_str(": x\n");
    settle_check("four_letter", 0, 1, 0);

    do_reset();
    push(15'h4AB1, 1, 0);
    send_str("svr:\n");
    settle_check("no_dest", 0, 1, 0);

    do_reset();
    push(15'h4AB1, 1, 0); push(15'h14B3, 0, 1);
    send_str("svr: fft");
    send(8'h0D);
    send(8'h0A);
    send(8'h00);
    settle_check("cr_nul", 1, 0, 1);

    do_reset();
    send_str("sv");
    do_reset();
    push(15'h0C02, 1, 0); push(15'h14B3, 0, 1);
    send_str("dac: fft\n");
    settle_check("mid_reset", 0, 0, 1);

    do_reset();
    for (int n = 0; n < 9; n++) begin
      push(15'h0022, 1, 0); push(15'h0C85, 0, 1);
      send_str("abc: def\n");
      chk("sat_line_cnt", o_line_cnt, (n + 1 > 7) ? 7 : n + 1);
    end
    settle_check("saturate", 0, 0, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
